// File: rtl/ifid_queue_pkg.sv
// ============================================================================
// Module  : ifid_queue_pkg
// Purpose : Shared bus widths, queue depth default, NOP encoding and the
//           pointer wrap helper for the IF/ID instruction queue.
// Contents: ADDR_BUS_WIDTH, INST_BUS_WIDTH, IFID_QUEUE_DEPTH, NOP_INST,
//           ptr_inc()
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

package ifid_queue_pkg;

  localparam int          ADDR_BUS_WIDTH   = 32;
  localparam int          INST_BUS_WIDTH   = 32;
  localparam int          IFID_QUEUE_DEPTH = 4;
  // All-zero instruction word is the bubble (NOP) seen by decode.
  localparam logic [31:0] NOP_INST         = 32'h0;

  // Advance a ring pointer, wrapping depth-1 -> 0 by explicit compare so a
  // non-power-of-two depth works.
  function automatic int unsigned ptr_inc(input int unsigned ptr,
                                          input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/ifid_queue_ram.sv
// ============================================================================
// Module  : ifid_queue_ram
// Purpose : DEPTH x WIDTH register array for the IF/ID queue. One synchronous
//           write port, one asynchronous read port. No reset (datapath only).
// Ports   : clk        clock
//           we_i       write enable
//           waddr_i    write index
//           wdata_i    write data
//           raddr_i    read index
//           rdata_o    read data (combinational)
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ifid_queue_ram #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 64,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             we_i,
  input  logic [PTR_W-1:0] waddr_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic [PTR_W-1:0] raddr_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_o = mem_q[raddr_i];

endmodule

`default_nettype wire

// File: rtl/ifid_queue.sv
// ============================================================================
// Module  : ifid_queue
// Purpose : DEPTH-entry FIFO of {addr, inst} pairs between the IF and ID
//           stages with valid/ready handshakes and a synchronous flush.
//           Optional same-cycle bypass when empty: IFID_QUEUE_BYPASS_EN.
// Ports   : clk                         clock
//           rst                         async reset, active low
//           flush                       discard all entries (priority)
//           in_valid/in_ready           IF handshake
//           in_addr/in_inst             fetched pair
//           out_valid/out_ready         ID handshake
//           out_addr/out_inst           head pair, zero when empty
//           count                       occupancy
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module ifid_queue
  import ifid_queue_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_BUS_WIDTH,
  parameter int INST_WIDTH = INST_BUS_WIDTH,
  parameter int DEPTH      = IFID_QUEUE_DEPTH
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [ADDR_WIDTH-1:0]      in_addr,
  input  logic [INST_WIDTH-1:0]      in_inst,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [ADDR_WIDTH-1:0]      out_addr,
  output logic [INST_WIDTH-1:0]      out_inst,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int               PTR_W      = $clog2(DEPTH);
  localparam int               CNT_W      = $clog2(DEPTH + 1);
  localparam int               DW         = ADDR_WIDTH + INST_WIDTH;
  localparam logic [CNT_W-1:0] C_FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic          w_mem_valid;
  logic          w_push;
  logic          w_pop;
  logic          w_wr;
  logic          w_bypass_take;
  logic [DW-1:0] w_rd_data;

  assign w_mem_valid = (count_q != '0);
  // Depends only on registered occupancy: no path from out_ready.
  assign in_ready    = (count_q != C_FULL_CNT);
  assign w_push      = in_valid && in_ready;
  // Memory-side pop; a bypassed word never occupies storage.
  assign w_pop       = w_mem_valid && out_ready;
  assign count       = count_q;

`ifdef IFID_QUEUE_BYPASS_EN
  logic w_bypass;
  assign w_bypass      = !w_mem_valid && !flush;
  assign w_bypass_take = w_bypass && in_valid && out_ready;
  assign out_valid     = w_bypass ? in_valid : w_mem_valid;
`else
  assign w_bypass_take = 1'b0;
  assign out_valid     = w_mem_valid;
`endif

  // A word consumed straight through the bypass is not written.
  assign w_wr = w_push && !w_bypass_take && !flush;

  always_comb begin
    out_addr = '0;
    out_inst = '0;
    if (w_mem_valid) begin
      out_addr = w_rd_data[DW-1 -: ADDR_WIDTH];
      out_inst = w_rd_data[INST_WIDTH-1:0];
    end
`ifdef IFID_QUEUE_BYPASS_EN
    else if (!flush) begin
      out_addr = in_addr;
      out_inst = in_inst;
    end
`endif
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (w_wr) wr_ptr_d = PTR_W'(ptr_inc(32'(wr_ptr_q), DEPTH));
      if (w_pop) rd_ptr_d = PTR_W'(ptr_inc(32'(rd_ptr_q), DEPTH));
      case ({w_wr, w_pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  ifid_queue_ram #(
    .DEPTH (DEPTH),
    .WIDTH (DW),
    .PTR_W (PTR_W)
  ) u_ram (
    .clk     (clk),
    .we_i    (w_wr),
    .waddr_i (wr_ptr_q),
    .wdata_i ({in_addr, in_inst}),
    .raddr_i (rd_ptr_q),
    .rdata_o (w_rd_data)
  );

endmodule

`default_nettype wire

// File: tb/tb_ifid_queue.sv
// ============================================================================
// Module  : tb_ifid_queue
// Purpose : Self-checking bench for ifid_queue (DEPTH=4). A queue-based
//           reference model predicts outputs every cycle; a vector table
//           checks fill/drain/flush; hand sequences cover reset, streaming,
//           bypass and asynchronous reset. Honours IFID_QUEUE_BYPASS_EN.
// Revision: 1.0  initial release
// ============================================================================
`default_nettype none

module tb_ifid_queue;

  localparam int AW    = 32;
  localparam int IW    = 32;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk       = 1'b0;
  logic          rst       = 1'b0;
  logic          flush     = 1'b0;
  logic          in_valid  = 1'b0;
  logic          in_ready;
  logic [AW-1:0] in_addr   = '0;
  logic [IW-1:0] in_inst   = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [AW-1:0] out_addr;
  logic [IW-1:0] out_inst;
  logic [CW-1:0] count;

  always #5 clk = ~clk;

  ifid_queue #(
    .ADDR_WIDTH (AW),
    .INST_WIDTH (IW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_addr   (in_addr),
    .in_inst   (in_inst),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_addr  (out_addr),
    .out_inst  (out_inst),
    .count     (count)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] a;
    logic [31:0] i;
  } entry_t;
  entry_t model_q[$];

  typedef struct {
    logic        f;
    logic        iv;
    logic [31:0] a;
    logic        ordy;
    int          ecnt;
    logic        erdy;
    logic        ev;
    logic [31:0] ea;
  } vec_t;
  vec_t tbl[15];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // One clock cycle: drive inputs, compare outputs with the model before the
  // edge, then advance the model by the handshake rules.
  task automatic cycle(input logic f, input logic iv, input logic [31:0] a,
                       input logic [31:0] ins, input logic ordy);
    int          sz;
    logic        exp_v, exp_rdy, take, pop, push;
    logic [31:0] exp_a, exp_i;
    flush = f; in_valid = iv; in_addr = a; in_inst = ins; out_ready = ordy;
    #4;
    sz      = model_q.size();
    exp_rdy = (sz != DEPTH);
    exp_v   = (sz != 0);
    exp_a   = '0;
    exp_i   = '0;
    if (sz != 0) begin
      exp_a = model_q[0].a;
      exp_i = model_q[0].i;
    end
`ifdef IFID_QUEUE_BYPASS_EN
    else if (!f) begin
      exp_v = iv;
      exp_a = a;
      exp_i = ins;
    end
`endif
    chk("m_count",     64'(count),     64'(sz));
    chk("m_in_ready",  64'(in_ready),  64'(exp_rdy));
    chk("m_out_valid", 64'(out_valid), 64'(exp_v));
    chk("m_out_addr",  64'(out_addr),  64'(exp_a));
    chk("m_out_inst",  64'(out_inst),  64'(exp_i));
    take = (sz == 0) && exp_v && ordy;
    pop  = (sz != 0) && ordy;
    push = iv && exp_rdy;
    @(posedge clk);
    if (f) begin
      model_q.delete();
    end else if (!take) begin
      if (pop)  void'(model_q.pop_front());
      if (push) model_q.push_back('{a: a, i: ins});
    end
    #1;
  endtask

  task automatic idle_inputs();
    flush = 1'b0; in_valid = 1'b0; in_addr = '0; in_inst = '0; out_ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Fill / drain / flush vectors; expectations are the state after the edge
    // observed with idle inputs.
    tbl[0]  = '{1'b0, 1'b1, 32'h100, 1'b0, 1, 1'b1, 1'b1, 32'h100};
    tbl[1]  = '{1'b0, 1'b1, 32'h104, 1'b0, 2, 1'b1, 1'b1, 32'h100};
    tbl[2]  = '{1'b0, 1'b1, 32'h108, 1'b0, 3, 1'b1, 1'b1, 32'h100};
    tbl[3]  = '{1'b0, 1'b1, 32'h10C, 1'b0, 4, 1'b0, 1'b1, 32'h100};
    tbl[4]  = '{1'b0, 1'b1, 32'h110, 1'b0, 4, 1'b0, 1'b1, 32'h100};
    tbl[5]  = '{1'b0, 1'b0, 32'h000, 1'b1, 3, 1'b1, 1'b1, 32'h104};
    tbl[6]  = '{1'b0, 1'b0, 32'h000, 1'b1, 2, 1'b1, 1'b1, 32'h108};
    tbl[7]  = '{1'b0, 1'b0, 32'h000, 1'b1, 1, 1'b1, 1'b1, 32'h10C};
    tbl[8]  = '{1'b0, 1'b0, 32'h000, 1'b1, 0, 1'b1, 1'b0, 32'h000};
    tbl[9]  = '{1'b0, 1'b1, 32'h0A0, 1'b0, 1, 1'b1, 1'b1, 32'h0A0};
    tbl[10] = '{1'b0, 1'b1, 32'h0A4, 1'b0, 2, 1'b1, 1'b1, 32'h0A0};
    tbl[11] = '{1'b0, 1'b1, 32'h0A8, 1'b0, 3, 1'b1, 1'b1, 32'h0A0};
    tbl[12] = '{1'b1, 1'b1, 32'h200, 1'b1, 0, 1'b1, 1'b0, 32'h000};
    tbl[13] = '{1'b0, 1'b1, 32'h300, 1'b0, 1, 1'b1, 1'b1, 32'h300};
    tbl[14] = '{1'b0, 1'b0, 32'h000, 1'b1, 0, 1'b1, 1'b0, 32'h000};

    // Reset held with in_valid high: nothing may be stored.
    rst = 1'b0; in_valid = 1'b1; in_addr = 32'h0DEAD; in_inst = 32'hBEEF;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    idle_inputs();
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_count",     64'(count),     64'd0);
    chk("rst_out_inst",  64'(out_inst),  64'd0);
    chk("rst_in_ready",  64'(in_ready),  64'd1);
    @(posedge clk); #1;
    chk("rst_count2", 64'(count), 64'd0);

    // Table-driven fill, drain and flush priority.
    for (int k = 0; k < 15; k++) begin
      cycle(tbl[k].f, tbl[k].iv, tbl[k].a, tbl[k].a ^ 32'h5A5A0000, tbl[k].ordy);
      idle_inputs();
      #1;
      chk($sformatf("t%0d_count", k),     64'(count),     64'(tbl[k].ecnt));
      chk($sformatf("t%0d_in_ready", k),  64'(in_ready),  64'(tbl[k].erdy));
      chk($sformatf("t%0d_out_valid", k), 64'(out_valid), 64'(tbl[k].ev));
      chk($sformatf("t%0d_out_addr", k),  64'(out_addr),  64'(tbl[k].ea));
    end

    // Steady stream at count=2 with push and pop every cycle (wraps pointers).
    cycle(1'b0, 1'b1, 32'h1000, 32'h71000, 1'b0);
    cycle(1'b0, 1'b1, 32'h1004, 32'h71004, 1'b0);
    for (int k = 0; k < 20; k++) begin
      cycle(1'b0, 1'b1, 32'h1008 + 32'(4 * k), 32'h71008 + 32'(4 * k), 1'b1);
      chk("stream_count", 64'(count), 64'd2);
    end
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    cycle(1'b0, 1'b0, '0, '0, 1'b1);
    chk("stream_empty", 64'(out_valid), 64'd0);

    // Bypass / baseline latency on an empty queue.
    cycle(1'b0, 1'b1, 32'h400, 32'h24020001, 1'b1);
`ifdef IFID_QUEUE_BYPASS_EN
    chk("byp_count", 64'(count), 64'd0);
`else
    chk("byp_count",    64'(count),    64'd1);
    chk("byp_out_inst", 64'(out_inst), 64'h24020001);
`endif
    cycle(1'b0, 1'b0, '0, '0, 1'b1);

    // Asynchronous reset between edges.
    cycle(1'b0, 1'b1, 32'h500, 32'h9, 1'b0);
    cycle(1'b0, 1'b1, 32'h504, 32'hA, 1'b0);
    idle_inputs();
    chk("ar_pre_count", 64'(count), 64'd2);
    #2 rst = 1'b0;
    #1;
    chk("ar_out_valid", 64'(out_valid), 64'd0);
    chk("ar_count",     64'(count),     64'd0);
    @(negedge clk) rst = 1'b1;
    model_q.delete();
    @(posedge clk); #1;

    // Randomised traffic against the model.
    for (int k = 0; k < 400; k++) begin
      cycle($urandom_range(0, 24) == 0, 1'($urandom), $urandom, $urandom,
            (k % 100 < 50) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
